// File: rtl/cond_flags_stage.sv
// Execute-to-writeback stage: owns NZCV, evaluates ARM condition codes, and registers
// the ALU result in a single-entry valid/ready slot. Optional macro: COND_STATS_EN.
module cond_flags_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cond,
    input  logic              in_s,
    input  logic [3:0]        in_flag_mask,
    input  logic              in_wr_en,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic [3:0]        cur_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wr_en,
    output logic              out_cond_pass
`ifdef COND_STATS_EN
    ,
    output logic [31:0]       stat_exec,
    output logic [31:0]       stat_annul
`endif
);

    localparam int unsigned FLAG_W = 4;

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic cond_pass;
    logic accept;
    logic flag_upd;

    assign flag_n = cur_flags[3];
    assign flag_z = cur_flags[2];
    assign flag_c = cur_flags[1];
    assign flag_v = cur_flags[0];

    // No skid buffer: the slot frees up in the same cycle writeback consumes it
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign flag_upd = accept && cond_pass && in_s;

    // Condition evaluation always sees the flags from before this instruction's own update
    always_comb begin
        cond_pass = 1'b0;
        case (in_cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Masked merge keeps C/V intact for logical ops that only produce N/Z
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_flags <= FLAG_W'(0);
        end else if (flag_upd) begin
            cur_flags <= (cur_flags & ~in_flag_mask) | (alu_flags & in_flag_mask);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_data      <= DATA_W'(0);
            out_rd        <= RD_W'(0);
            out_wr_en     <= 1'b0;
            out_cond_pass <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_data      <= alu_result;
            out_rd        <= in_rd;
            out_wr_en     <= in_wr_en && cond_pass;
            out_cond_pass <= cond_pass;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

`ifdef COND_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_exec  <= 32'(0);
            stat_annul <= 32'(0);
        end else if (accept) begin
            if (cond_pass) begin
                stat_exec  <= stat_exec + 32'(1);
            end else begin
                stat_annul <= stat_annul + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cond_flags_stage.sv
// Directed table-driven bench for cond_flags_stage, with hand sequences for
// backpressure, back-to-back streaming and mid-entry reset.
module tb_cond_flags_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cond;
    logic        in_s;
    logic [3:0]  in_flag_mask;
    logic        in_wr_en;
    logic [3:0]  in_rd;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [3:0]  cur_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_rd;
    logic        out_wr_en;
    logic        out_cond_pass;
`ifdef COND_STATS_EN
    logic [31:0] stat_exec;
    logic [31:0] stat_annul;
`endif

    cond_flags_stage #(.DATA_W(32), .RD_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_cond       (in_cond),
        .in_s          (in_s),
        .in_flag_mask  (in_flag_mask),
        .in_wr_en      (in_wr_en),
        .in_rd         (in_rd),
        .alu_result    (alu_result),
        .alu_flags     (alu_flags),
        .cur_flags     (cur_flags),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_rd        (out_rd),
        .out_wr_en     (out_wr_en),
        .out_cond_pass (out_cond_pass)
`ifdef COND_STATS_EN
        ,
        .stat_exec     (stat_exec),
        .stat_annul    (stat_annul)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  cond;
        logic        s;
        logic [3:0]  mask;
        logic        wr;
        logic [3:0]  rd;
        logic [31:0] res;
        logic [3:0]  af;
        logic [3:0]  e_flags;
        logic        e_ov;
        logic        e_pass;
        logic        e_wr;
        logic [31:0] e_data;
        logic [3:0]  e_rd;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl[NVEC];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   exp_exec  = 0;
    int   exp_annul = 0;

    function automatic vec_t mk(logic v, logic [3:0] cond, logic s, logic [3:0] mask,
                                logic wr, logic [3:0] rd, logic [31:0] res, logic [3:0] af,
                                logic [3:0] e_flags, logic e_ov, logic e_pass, logic e_wr,
                                logic [31:0] e_data, logic [3:0] e_rd);
        vec_t r;
        r.v = v; r.cond = cond; r.s = s; r.mask = mask; r.wr = wr; r.rd = rd;
        r.res = res; r.af = af; r.e_flags = e_flags; r.e_ov = e_ov;
        r.e_pass = e_pass; r.e_wr = e_wr; r.e_data = e_data; r.e_rd = e_rd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] cond, input logic s, input logic [3:0] mask,
                         input logic wr, input logic [3:0] rd, input logic [31:0] res, input logic [3:0] af);
        in_valid = v; in_cond = cond; in_s = s; in_flag_mask = mask;
        in_wr_en = wr; in_rd = rd; alu_result = res; alu_flags = af;
    endtask

    initial begin
        //             v cond  s mask  wr rd  res        af   | flags ov pass wr data       rd
        tbl[0]  = mk(1, 4'hE, 1, 4'hF, 1, 1, 32'h0,     4'h6, 4'h6, 1, 1, 1, 32'h0,     1); // SUBS
        tbl[1]  = mk(1, 4'h0, 0, 4'h0, 0, 0, 32'h100,   4'h0, 4'h6, 1, 1, 0, 32'h100,   0); // BEQ
        tbl[2]  = mk(1, 4'h1, 0, 4'h0, 1, 2, 32'h200,   4'h0, 4'h6, 1, 0, 0, 32'h200,   2); // BNE
        tbl[3]  = mk(0, 4'hE, 1, 4'hF, 1, 9, 32'h999,   4'hF, 4'h6, 0, 0, 0, 32'h200,   2); // idle
        tbl[4]  = mk(1, 4'hE, 1, 4'hF, 0, 3, 32'h5,     4'h3, 4'h3, 1, 1, 0, 32'h5,     3);
        tbl[5]  = mk(1, 4'hE, 1, 4'hC, 1, 4, 32'h8,     4'h8, 4'hB, 1, 1, 1, 32'h8,     4); // ANDS
        tbl[6]  = mk(1, 4'hC, 0, 4'h0, 1, 5, 32'h6,     4'h0, 4'hB, 1, 1, 1, 32'h6,     5); // GT
        tbl[7]  = mk(1, 4'hB, 0, 4'h0, 1, 6, 32'h7,     4'h0, 4'hB, 1, 0, 0, 32'h7,     6); // LT
        tbl[8]  = mk(1, 4'h8, 0, 4'h0, 1, 7, 32'h8,     4'h0, 4'hB, 1, 1, 1, 32'h8,     7); // HI
        tbl[9]  = mk(1, 4'hF, 0, 4'h0, 1, 8, 32'h9,     4'h0, 4'hB, 1, 0, 0, 32'h9,     8); // NV
        tbl[10] = mk(1, 4'hE, 1, 4'hF, 1, 1, 32'h0,     4'h8, 4'h8, 1, 1, 1, 32'h0,     1);
        tbl[11] = mk(1, 4'hB, 0, 4'h0, 1, 2, 32'h11,    4'h0, 4'h8, 1, 1, 1, 32'h11,    2); // LT
        tbl[12] = mk(1, 4'hA, 0, 4'h0, 1, 3, 32'h12,    4'h0, 4'h8, 1, 0, 0, 32'h12,    3); // GE
        tbl[13] = mk(1, 4'hC, 0, 4'h0, 1, 4, 32'h13,    4'h0, 4'h8, 1, 0, 0, 32'h13,    4); // GT
        tbl[14] = mk(1, 4'hD, 0, 4'h0, 1, 5, 32'h14,    4'h0, 4'h8, 1, 1, 1, 32'h14,    5); // LE
        tbl[15] = mk(1, 4'hE, 1, 4'hF, 1, 6, 32'h15,    4'h0, 4'h0, 1, 1, 1, 32'h15,    6);
        tbl[16] = mk(1, 4'h0, 1, 4'hF, 1, 7, 32'h16,    4'hF, 4'h0, 1, 0, 0, 32'h16,    7); // ADDEQS annulled
        tbl[17] = mk(0, 4'hE, 1, 4'hF, 1, 0, 32'h0,     4'hF, 4'h0, 0, 0, 0, 32'h16,    7); // idle

        reset = 1'b1;
        out_ready = 1'b1;
        drive(0, 4'h0, 0, 4'h0, 0, 4'h0, 32'h0, 4'h0);
        #12;
        reset = 1'b0;
        #1;
        chk("reset_flags", 32'(cur_flags), 32'h0);
        chk("reset_ov", 32'(out_valid), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        chk("reset_data", out_data, 32'h0);
        chk("reset_pass", 32'(out_cond_pass), 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].v, tbl[i].cond, tbl[i].s, tbl[i].mask, tbl[i].wr,
                  tbl[i].rd, tbl[i].res, tbl[i].af);
            step();
            if (tbl[i].v) begin
                if (tbl[i].e_pass) exp_exec++;
                else exp_annul++;
            end
            chk($sformatf("v%0d_flags", i), 32'(cur_flags), 32'(tbl[i].e_flags));
            chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d_pass", i), 32'(out_cond_pass), 32'(tbl[i].e_pass));
            chk($sformatf("v%0d_wr", i), 32'(out_wr_en), 32'(tbl[i].e_wr));
            chk($sformatf("v%0d_data", i), out_data, tbl[i].e_data);
            chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(tbl[i].e_rd));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'h1);
        end

`ifdef COND_STATS_EN
        chk("stat_exec", stat_exec, 32'(exp_exec));
        chk("stat_annul", stat_annul, 32'(exp_annul));
`endif

        // Backpressure: entry held, second S-instruction stalled with no flag change
        out_ready = 1'b0;
        drive(1, 4'hE, 1, 4'hF, 1, 4'h7, 32'hAA, 4'h4);
        step();
        chk("bp_load_data", out_data, 32'hAA);
        chk("bp_load_flags", 32'(cur_flags), 32'h4);
        chk("bp_load_ov", 32'(out_valid), 32'h1);
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        drive(1, 4'hE, 1, 4'hF, 1, 4'h8, 32'hBB, 4'hF);
        step();
        chk("bp_hold_data", out_data, 32'hAA);
        chk("bp_hold_flags", 32'(cur_flags), 32'h4);
        chk("bp_hold_ov", 32'(out_valid), 32'h1);
        chk("bp_hold_in_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'h1);
        step();
        chk("bp_swap_data", out_data, 32'hBB);
        chk("bp_swap_rd", 32'(out_rd), 32'h8);
        chk("bp_swap_flags", 32'(cur_flags), 32'hF);
        chk("bp_swap_ov", 32'(out_valid), 32'h1);

        // Back-to-back stream of four, one per cycle
        for (int k = 1; k <= 4; k++) begin
            drive(1, 4'hE, 0, 4'h0, 1, 4'(k), 32'(k * 16), 4'h0);
            step();
            chk($sformatf("stream%0d_data", k), out_data, 32'(k * 16));
            chk($sformatf("stream%0d_ov", k), 32'(out_valid), 32'h1);
        end

        // Reset arriving while an entry is held and an S-instruction is offered
        drive(1, 4'hE, 1, 4'hF, 1, 4'h3, 32'h55, 4'h5);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async_ov", 32'(out_valid), 32'h0);
        chk("rst_async_flags", 32'(cur_flags), 32'h0);
        chk("rst_async_data", out_data, 32'h0);
        chk("rst_async_in_ready", 32'(in_ready), 32'h1);
        step();
        chk("rst_edge_flags", 32'(cur_flags), 32'h0);
        chk("rst_edge_ov", 32'(out_valid), 32'h0);
        #3;
        reset = 1'b0;
        drive(0, 4'hE, 1, 4'hF, 1, 4'h3, 32'h55, 4'h5);
        step();
        chk("post_rst_flags", 32'(cur_flags), 32'h0);
        chk("post_rst_ov", 32'(out_valid), 32'h0);
`ifdef COND_STATS_EN
        chk("post_rst_stat_exec", stat_exec, 32'h0);
        chk("post_rst_stat_annul", stat_annul, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_flags_stage.md
Name: cond_flags_stage

Overview:
- Execute-to-writeback stage placed directly downstream of the ALU.
- Owns the architectural NZCV register and drives it back to the ALU as its current-flags input.
- Evaluates each instruction's 4-bit ARM condition field against NZCV, then registers the ALU result and destination for writeback.
- Updates NZCV from the ALU's new flags when the instruction passes its condition and has the S bit set.
- Uses a single-entry valid/ready output register to decouple execute from writeback.

Parameters:
- DATA_W, 32, width of ALU result and writeback data.
- RD_W, 4, width of destination register index.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_cond  in  4  ARM condition field (instr[31:28]).
- in_s  in  1  S bit: instruction may update flags.
- in_flag_mask  in  4  NZCV bits this opcode affects (arith 1111, logic/move 1100, mul 1100, mem/branch 0000).
- in_wr_en  in  1  instruction writes Rd.
- in_rd  in  RD_W  destination register index.
- alu_result  in  DATA_W  ALU result.
- alu_flags  in  4  ALU new flags, NZCV order.
- cur_flags  out  4  architectural NZCV; feeds the ALU current-flags input.
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  writeback consumes entry.
- out_data  out  DATA_W  registered result.
- out_rd  out  RD_W  registered destination.
- out_wr_en  out  1  registered in_wr_en AND cond_pass.
- out_cond_pass  out  1  registered condition outcome; 0 = annulled.

Behaviour:
- Reset (async, immediate):
  - cur_flags=0000, out_valid=0, out_data=0, out_rd=0, out_wr_en=0, out_cond_pass=0.
  - Any held entry is discarded.
  - Reset asserted mid-handshake: the entry is lost, and no flag update occurs at that edge.
- in_ready = !out_valid || out_ready. This is combinational from out_ready; there is no skid buffer.
- Accept: in_valid && in_ready at a rising clk edge.
  - On accept, the out_* registers load and out_valid=1, one cycle latency.
- Consume: out_valid && out_ready with no accept in the same cycle leaves out_valid=0; out_* data holds its old values.
- Simultaneous consume and accept: the new entry replaces the old one; out_valid stays 1. This is full throughput, one per cycle.
- cond_pass is combinational from in_cond and cur_flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V.
  - GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) 1; 1111 (NV) 0.
- Flag update:
  - Occurs only on accept && cond_pass && in_s.
  - cur_flags <= (cur_flags & ~in_flag_mask) | (alu_flags & in_flag_mask).
  - Unmasked bits are preserved; this keeps C/V intact for logical ops.
- Annulled instruction (cond_pass=0):
  - Still accepted and forwarded with out_cond_pass=0 and out_wr_en=0.
  - No flag change.
- Ordering: the condition is always evaluated against cur_flags before the current instruction's own update. The next accepted instruction sees the updated flags, because the update occurs at the same edge as accept.
- No accept leaves cur_flags unchanged, regardless of in_s or alu_flags.
- in_* inputs are ignored when in_valid=0.

Optional Feature:
- Macro COND_STATS_EN.
- When defined:
  - Adds outputs stat_exec (32) and stat_annul (32).
  - On each accept, stat_exec increments if cond_pass=1, else stat_annul increments.
  - Both counters wrap modulo 2^32 and reset to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: cur_flags=0000, out_valid=0, in_ready=1. Assert reset while out_valid=1 -> out_valid drops immediately, cur_flags=0000.
- Flag update: accept SUBS (cond=1110, s=1, mask=1111, alu_flags=0110, result=0) -> next cycle cur_flags=0110, out_cond_pass=1, out_wr_en=1. Then BEQ (cond=0000) -> out_cond_pass=1. Then BNE (cond=0001) -> out_cond_pass=0, out_wr_en=0.
- Mask preservation: cur_flags=0011, accept ANDS (mask=1100, alu_flags=1000) -> cur_flags=1011.
- Annulled S-instruction: cur_flags=0000, accept ADDEQS (cond=0000, s=1, alu_flags=1111) -> cur_flags stays 0000, out_cond_pass=0.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out_data held, no flag change despite in_valid=1 with s=1. Raise out_ready while in_valid=1 -> entry swapped in one cycle; back-to-back stream of 4 instructions completes in 4 cycles.
- Signed conditions: cur_flags N=1,V=0 -> LT pass, GE fail, GT fail, LE pass. cur_flags N=1,V=1,Z=0 -> GT pass. COND_STATS_EN build: 3 executed + 2 annulled -> stat_exec=3, stat_annul=2.
